registers_term_mc: RTL and testbench
====================================

# registers_term_mc

Parametrised multi-channel register-cycle terminator for the SCSI DMA controller's register bus. It watches the CPU address strobe and a one-hot vector of register-region selects, and inserts a per-channel programmable number of wait states. It then drives the active-low register acknowledge, either held or as a fixed-length pulse. An optional watchdog flags strobes that no channel claims.

## Interface
Parameters:
- NSEL, 4, number of select channels (1..8)
- CNT_W, 3, wait-state counter width; per-channel wait range 0..2^CNT_W-1
- WR_EXTRA, 0, extra wait states added to write cycles (0..2^CNT_W-1)
- PULSE_LEN, 0, acknowledge length in cycles; 0 = hold until AS_ negates
- TO_W, 6, watchdog counter width (used only with TERM_TIMEOUT_EN)

Ports:
- CLK  in  1  bus clock; all state changes on rising edge
- RST  in  1  reset; synchronous, active-high
- AS_  in  1  CPU address strobe, active low, already synchronised to CLK
- SEL  in  NSEL  one-hot region selects, active high
- RW  in  1  1 = read, 0 = write; sampled at accept
- WAIT_CFG  in  NSEL*CNT_W  wait states for channel i in bits [i*CNT_W +: CNT_W]
- REG_DSK_  out  1  register acknowledge, active low, registered
- BUSY  out  1  high while a cycle is owned (state != IDLE)
- CH  out  3  index of the accepted channel, valid while BUSY
- TIMEOUT  out  1  unclaimed-strobe flag, active high

## Operation
- States: IDLE, WAIT, TERM, DONE.
- IDLE: AS_=0 and any SEL bit set -> accept. Latch CH = lowest set index and load CNT = WAIT_CFG[CH], or CNT = WAIT_CFG[CH] + WR_EXTRA when RW=0, saturating at 2^CNT_W-1. Go to WAIT. AS_=0 with SEL=0 -> stay IDLE.
- WAIT: CNT != 0 -> CNT decrements. CNT == 0 -> REG_DSK_ <= 0, go to TERM, load pulse counter with PULSE_LEN-1.
- TERM, PULSE_LEN=0: REG_DSK_ held low until AS_ negates.
- TERM, PULSE_LEN>0: REG_DSK_ low for PULSE_LEN cycles, then REG_DSK_ <= 1 and go to DONE.
- DONE: REG_DSK_=1; wait for AS_ negation.
- AS_=1 sampled in WAIT, TERM or DONE -> IDLE, REG_DSK_ <= 1, BUSY <= 0 on the same edge. This covers an abort mid-WAIT: no acknowledge is issued.
- SEL, RW and WAIT_CFG changes after accept are ignored until the next accept.
- A new accept needs AS_ sampled high at least once; back-to-back cycles are separated by at least one IDLE cycle.
- RST=1 overrides everything, including AS_ activity on the same edge.

## Timing
- Accept edge E0. REG_DSK_ falls at edge E0 + 1 + W, where W is the loaded CNT.
  - W=0: acknowledge one cycle after accept.
  - W=1: acknowledge at the second edge of the active cycle.
- PULSE_LEN=P>0: REG_DSK_ low for exactly P edges-to-edge cycles, unless AS_ negates first.
- REG_DSK_ returns high on the first edge where AS_=1 is sampled. AS_-to-release latency is 1 cycle.
- Reset values: REG_DSK_=1, BUSY=0, CH=0, TIMEOUT=0, state IDLE, counters 0.
- BUSY rises on E0 and falls on the edge that returns to IDLE.

## Configuration
- TERM_TIMEOUT_EN defined:
  - Watchdog counter of width TO_W increments every cycle AS_=0 and state=IDLE; clears when AS_=1 or on accept.
  - Reaching 2^TO_W-1 sets TIMEOUT=1, held until AS_ is sampled high; the counter stops at that value.
  - An accept in the same cycle the count saturates wins: TIMEOUT stays 0.
- TERM_TIMEOUT_EN undefined: no watchdog logic; TIMEOUT is constant 0 and TO_W is unused.

## Test plan
- Read, NSEL=4, WAIT_CFG ch2=1, SEL=4'b0100, AS_ low at E0 -> REG_DSK_ low at E2, CH=2, BUSY=1; AS_ high -> REG_DSK_=1, BUSY=0 next edge.
- Write, WR_EXTRA=2, ch0 wait=6, CNT_W=3 -> loaded CNT saturates at 7, REG_DSK_ low at E8. Same setup with ch0 wait=0 -> REG_DSK_ low at E3.
- PULSE_LEN=2, ch1 wait=0, AS_ held low 10 cycles -> REG_DSK_ low for E1..E2 only, DONE until AS_ high, no second acknowledge.
- SEL=4'b1010 -> CH=1. AS_ negated while in WAIT with CNT=3 -> REG_DSK_ never falls, IDLE next edge.
- RST asserted while in TERM -> next edge REG_DSK_=1, BUSY=0, CH=0. New cycle after RST release behaves normally.
- TERM_TIMEOUT_EN, TO_W=4, AS_ low with SEL=0 for 20 cycles -> TIMEOUT=1 at the 15th edge, cleared on the edge after AS_ high. Without the macro -> TIMEOUT stays 0.

Source files
------------

// File: rtl/registers_term_mc.sv
// registers_term_mc: multi-channel register-cycle terminator for the SCSI DMA
// register bus. An accepted strobe is held for a per-channel number of wait
// states before REG_DSK_ is driven low, either held or as a fixed pulse.
// Optional feature macro: TERM_TIMEOUT_EN adds a watchdog that flags strobes
// no channel claims. Without it TIMEOUT is tied low.
module registers_term_mc #(
   parameter int NSEL      = 4,
   parameter int CNT_W     = 3,
   parameter int WR_EXTRA  = 0,
   parameter int PULSE_LEN = 0,
   parameter int TO_W      = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  AS_,
   input  logic [NSEL-1:0]       SEL,
   input  logic                  RW,
   input  logic [NSEL*CNT_W-1:0] WAIT_CFG,
   output logic                  REG_DSK_,
   output logic                  BUSY,
   output logic [2:0]            CH,
   output logic                  TIMEOUT
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_TERM, ST_DONE} state_t;

   // Pulse counter only needs to hold PULSE_LEN-1.
   localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam logic [PW-1:0] PLOAD = PW'((PULSE_LEN > 0) ? (PULSE_LEN - 1) : 0);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [PW-1:0]    r_pcnt;
   logic             r_dsk_n;
   logic             r_busy;
   logic [2:0]       r_ch;

   logic             w_any_sel;
   logic             w_accept;
   logic [2:0]       w_sel_idx;
   logic [CNT_W-1:0] w_sel_cfg;

   // Wait count for an accepted cycle; writes get WR_EXTRA more, clamped to the counter range.
   function automatic logic [CNT_W-1:0] sat_load(input logic [CNT_W-1:0] base, input logic is_wr);
      logic [CNT_W:0] sum;
      sum = {1'b0, base} + (is_wr ? (CNT_W+1)'(WR_EXTRA) : '0);
      if (sum[CNT_W])
         return '1;
      else
         return sum[CNT_W-1:0];
   endfunction

   // Lowest-index selected channel and its wait configuration.
   always_comb begin
      w_sel_idx = '0;
      w_sel_cfg = '0;
      for (int i = NSEL - 1; i >= 0; i--) begin
         if (SEL[i]) begin
            w_sel_idx = 3'(i);
            w_sel_cfg = WAIT_CFG[i*CNT_W +: CNT_W];
         end
      end
   end

   assign w_any_sel = |SEL;
   assign w_accept  = (r_state == ST_IDLE) && !AS_ && w_any_sel;

   // Cycle FSM: accept, count wait states, acknowledge, release on AS_ negation.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_pcnt  <= '0;
         r_dsk_n <= 1'b1;
         r_busy  <= 1'b0;
         r_ch    <= '0;
      end else if (r_state == ST_IDLE) begin
         if (w_accept) begin
            r_ch    <= w_sel_idx;
            r_cnt   <= sat_load(w_sel_cfg, !RW);
            r_busy  <= 1'b1;
            r_state <= ST_WAIT;
         end
      end else if (AS_) begin
         // Strobe gone: end the cycle wherever it is, including an abort before acknowledge.
         r_state <= ST_IDLE;
         r_dsk_n <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_dsk_n <= 1'b0;
                  r_pcnt  <= PLOAD;
                  r_state <= ST_TERM;
               end
            end
            ST_TERM: begin
               // With PULSE_LEN=0 the acknowledge is simply held until AS_ rises.
               if (PULSE_LEN > 0) begin
                  if (r_pcnt == '0) begin
                     r_dsk_n <= 1'b1;
                     r_state <= ST_DONE;
                  end else begin
                     r_pcnt <= r_pcnt - 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign REG_DSK_ = r_dsk_n;
   assign BUSY     = r_busy;
   assign CH       = r_ch;

`ifdef TERM_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_PRE = {{(TO_W-1){1'b1}}, 1'b0};

   logic [TO_W-1:0] r_to_cnt;
   logic            r_timeout;

   // Watchdog: count idle strobe cycles nobody claims, flag at saturation until AS_ rises.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else if (AS_) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else if (w_accept) begin
         r_to_cnt <= '0;
      end else if ((r_state == ST_IDLE) && (r_to_cnt != '1)) begin
         r_to_cnt <= r_to_cnt + 1'b1;
         if (r_to_cnt == TO_PRE)
            r_timeout <= 1'b1;
      end
   end

   assign TIMEOUT = r_timeout;
`else
   assign TIMEOUT = 1'b0 & (TO_W > 0);
`endif

endmodule

// File: tb/tb_registers_term_mc.sv
// Bench for registers_term_mc: two instances (held ack / 2-cycle pulse with
// different write extras) driven by shared stimulus, checked every cycle
// against a timing-level model plus directed literal expectations.
module tb_registers_term_mc;

   localparam int WX [2] = '{2, 0};
   localparam int PL [2] = '{0, 2};
   localparam int TOMAX  = 15;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        AS_ = 1'b1;
   logic [3:0]  SEL = '0;
   logic        RW  = 1'b1;
   logic [11:0] WAIT_CFG = '0;

   logic       dsk [2];
   logic       busy [2];
   logic [2:0] ch [2];
   logic       tout [2];

   int total = 0;
   int bad   = 0;

   registers_term_mc #(.NSEL(4), .CNT_W(3), .WR_EXTRA(2), .PULSE_LEN(0), .TO_W(4)) u_a (
      .CLK(CLK), .RST(RST), .AS_(AS_), .SEL(SEL), .RW(RW), .WAIT_CFG(WAIT_CFG),
      .REG_DSK_(dsk[0]), .BUSY(busy[0]), .CH(ch[0]), .TIMEOUT(tout[0]));

   registers_term_mc #(.NSEL(4), .CNT_W(3), .WR_EXTRA(0), .PULSE_LEN(2), .TO_W(4)) u_b (
      .CLK(CLK), .RST(RST), .AS_(AS_), .SEL(SEL), .RW(RW), .WAIT_CFG(WAIT_CFG),
      .REG_DSK_(dsk[1]), .BUSY(busy[1]), .CH(ch[1]), .TIMEOUT(tout[1]));

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // ---------------- behavioural model (timing arithmetic) ----------------
   int cyc = 0;
   bit m_valid = 0;
   bit m_busy [2];
   int m_ch   [2];
   int m_tacc [2];
   int m_w    [2];
   int m_run  = 0;
   bit m_to   = 0;

   function automatic int lowest(input logic [3:0] s);
      for (int i = 0; i < 4; i++)
         if (s[i]) return i;
      return 0;
   endfunction

   always @(posedge CLK) begin
      bit was_busy;
      cyc++;
      was_busy = m_busy[0];
      if (RST) begin
         m_run = 0;
         m_to  = 0;
      end else if (AS_) begin
         m_run = 0;
         m_to  = 0;
      end else if (!was_busy && SEL == 0) begin
         m_run++;
         if (m_run >= TOMAX) m_to = 1;
      end else if (!was_busy) begin
         m_run = 0;
      end
      for (int k = 0; k < 2; k++) begin
         if (RST) begin
            m_busy[k] = 0;
            m_ch[k]   = 0;
         end else if (m_busy[k]) begin
            if (AS_) m_busy[k] = 0;
         end else if (!AS_ && SEL != 0) begin
            int c, w;
            c = lowest(SEL);
            w = int'(WAIT_CFG[c*3 +: 3]) + (RW ? 0 : WX[k]);
            m_busy[k] = 1;
            m_ch[k]   = c;
            m_tacc[k] = cyc;
            m_w[k]    = (w > 7) ? 7 : w;
         end
      end
      if (RST) m_valid = 1;
   end

   function automatic int exp_dsk(input int k);
      int f;
      if (!m_busy[k]) return 1;
      f = m_tacc[k] + 1 + m_w[k];
      if (cyc < f) return 1;
      if (PL[k] == 0) return 0;
      return (cyc < f + PL[k]) ? 0 : 1;
   endfunction

   function automatic int exp_to();
`ifdef TERM_TIMEOUT_EN
      return int'(m_to);
`else
      return 0;
`endif
   endfunction

   // Per-cycle compare against the model.
   always @(negedge CLK) begin
      if (m_valid) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("model dsk[%0d] cyc%0d", k, cyc), int'(dsk[k]), exp_dsk(k));
            chk($sformatf("model busy[%0d] cyc%0d", k, cyc), int'(busy[k]), int'(m_busy[k]));
            if (m_busy[k])
               chk($sformatf("model ch[%0d] cyc%0d", k, cyc), int'(ch[k]), m_ch[k]);
            chk($sformatf("model timeout[%0d] cyc%0d", k, cyc), int'(tout[k]), exp_to());
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [9:0] v;
      bit saw_low;
      int len;

      RST = 1'b1; AS_ = 1'b1;
      tick(); tick();
      for (int k = 0; k < 2; k++) begin
         chk("reset dsk", int'(dsk[k]), 1);
         chk("reset busy", int'(busy[k]), 0);
         chk("reset ch", int'(ch[k]), 0);
         chk("reset timeout", int'(tout[k]), 0);
      end
      RST = 1'b0;
      tick();

      // Read, ch2 wait=1: ack at E2.
      SEL = 4'b0100; RW = 1'b1; WAIT_CFG = 12'o0100; AS_ = 1'b0;
      tick();
      chk("t1 busy E0", int'(busy[0]), 1);
      chk("t1 ch E0", int'(ch[0]), 2);
      chk("t1 dsk E0", int'(dsk[0]), 1);
      tick();
      chk("t1 dsk E1", int'(dsk[0]), 1);
      tick();
      chk("t1 dsk E2", int'(dsk[0]), 0);
      chk("t1 dskB E2", int'(dsk[1]), 0);
      AS_ = 1'b1;
      tick();
      chk("t1 release dsk", int'(dsk[0]), 1);
      chk("t1 release busy", int'(busy[0]), 0);

      // Write, ch0 wait=6 + extra 2 saturates at 7: ack at E8.
      SEL = 4'b0001; RW = 1'b0; WAIT_CFG = 12'o0006; AS_ = 1'b0;
      tick();
      repeat (7) tick();
      chk("t2 sat dsk E7", int'(dsk[0]), 1);
      tick();
      chk("t2 sat dsk E8", int'(dsk[0]), 0);
      AS_ = 1'b1;
      tick();
      // Write, ch0 wait=0 + extra 2: ack at E3 (instance B has no extra: E1).
      WAIT_CFG = 12'o0000; AS_ = 1'b0;
      tick();
      tick();
      chk("t2 B dsk E1", int'(dsk[1]), 0);
      chk("t2 A dsk E1", int'(dsk[0]), 1);
      tick();
      chk("t2 A dsk E2", int'(dsk[0]), 1);
      tick();
      chk("t2 A dsk E3", int'(dsk[0]), 0);
      AS_ = 1'b1;
      tick();

      // Pulse of 2 on ch1 wait=0, strobe held 10 cycles.
      SEL = 4'b0010; RW = 1'b1; WAIT_CFG = 12'o0000; AS_ = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         v[i] = dsk[1];
      end
      chk("t3 pulse pattern", int'(v), int'(10'b1111111100));
      chk("t3 still busy", int'(busy[1]), 1);
      AS_ = 1'b1;
      tick();

      // SEL=1010 picks ch1; abort in WAIT with CNT=3.
      SEL = 4'b1010; WAIT_CFG = 12'o0050; AS_ = 1'b0; saw_low = 0;
      tick();
      chk("t4 ch", int'(ch[0]), 1);
      tick(); saw_low |= !dsk[0];
      tick(); saw_low |= !dsk[0];
      AS_ = 1'b1;
      tick(); saw_low |= !dsk[0];
      chk("t4 abort busy", int'(busy[0]), 0);
      chk("t4 no ack", int'(saw_low), 0);

      // Reset while in TERM, then a normal cycle.
      SEL = 4'b0001; WAIT_CFG = 12'o0000; AS_ = 1'b0;
      tick(); tick();
      chk("t5 in term", int'(dsk[0]), 0);
      RST = 1'b1;
      tick();
      chk("t5 rst dsk", int'(dsk[0]), 1);
      chk("t5 rst busy", int'(busy[0]), 0);
      chk("t5 rst ch", int'(ch[0]), 0);
      RST = 1'b0; AS_ = 1'b1;
      tick();
      SEL = 4'b0100; WAIT_CFG = 12'o0100; AS_ = 1'b0;
      tick(); tick(); tick();
      chk("t5 after rst dsk", int'(dsk[0]), 0);
      chk("t5 after rst ch", int'(ch[0]), 2);
      AS_ = 1'b1;
      tick();

      // Unclaimed strobe for 20 cycles.
      SEL = 4'b0000; AS_ = 1'b0;
      repeat (14) tick();
      chk("t6 timeout edge14", int'(tout[0]), 0);
      tick();
`ifdef TERM_TIMEOUT_EN
      chk("t6 timeout edge15", int'(tout[0]), 1);
`else
      chk("t6 timeout edge15", int'(tout[0]), 0);
`endif
      repeat (5) tick();
      AS_ = 1'b1;
      tick();
      chk("t6 timeout cleared", int'(tout[0]), 0);

      // Randomized bus cycles.
      for (int t = 0; t < 300; t++) begin
         SEL = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
         RW = 1'($urandom);
         WAIT_CFG = 12'($urandom);
         AS_ = 1'b0;
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 50) == 0) RST = 1'b1;
            tick();
            RST = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
               SEL = 4'($urandom);
               RW = 1'($urandom);
               WAIT_CFG = 12'($urandom);
            end
         end
         AS_ = 1'b1;
         repeat ($urandom_range(1, 2)) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
